alu_issue_ctrl: RTL and testbench

//  Initiator side of the behavioural ALU interface (R0/R2/R3/ALUOp).

---
 rtl/alu_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: instruction issue controller for an external combinational ALU.
// Accepts one 3-operand instruction at a time (valid/ready), reads its operands
// from an internal 8 x W register file, presents them to the ALU for one full
// cycle, captures the ALU result, writes it back and pulses res_valid.
// Sequence per instruction: IDLE (accept) -> EXEC (ALU settles) -> WB (report).
module alu_issue_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  // instruction source
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs,
  input  logic [2:0]   in_rt,
  input  logic [W-1:0] in_imm,
  // ALU side
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  // result report
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_rd,
  // register-file debug port
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  localparam int NREGS = 8;

  // Opcodes that the controller treats specially; 000-101 go straight to the ALU.
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t         state_reg, state_next;

  logic [W-1:0]   alu_a_reg, alu_a_next;
  logic [W-1:0]   alu_b_reg, alu_b_next;
  logic [2:0]     alu_op_reg, alu_op_next;
  logic [2:0]     rd_reg, rd_next;
  logic           nop_reg, nop_next;
  logic [W-1:0]   res_data_reg, res_data_next;
  logic [2:0]     res_rd_reg, res_rd_next;

  // Register file kept in flops: reset must clear every entry in one edge.
  logic [W-1:0]   regfile_reg [NREGS];
  logic           wr_en;
  logic [NREGS-1:0] wr_sel;

  logic [W-1:0]   rs_data;
  logic [W-1:0]   rt_data;

  // Operand reads for the instruction being offered; only used in IDLE.
  assign rs_data = regfile_reg[in_rs];
  assign rt_data = regfile_reg[in_rt];

  // Per-register write strobes decoded from the latched destination.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (rd_reg == 3'(gi));
    end
  endgenerate

  // Next-state and next-datapath logic; everything holds unless a state acts on it.
  always_comb begin
    state_next    = state_reg;
    alu_a_next    = alu_a_reg;
    alu_b_next    = alu_b_reg;
    alu_op_next   = alu_op_reg;
    rd_next       = rd_reg;
    nop_next      = nop_reg;
    res_data_next = res_data_reg;
    res_rd_next   = res_rd_reg;
    wr_en         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = EXEC;
          rd_next    = in_rd;
          nop_next   = (in_op == OP_NOP);
          case (in_op)
            OP_LDI: begin
              // Immediate passes through the ALU via its pass-through op.
              alu_a_next  = in_imm;
              alu_b_next  = '0;
              alu_op_next = OP_PASS;
            end
            OP_NOP: begin
              // ALU returns 0 for this op; the result is reported but never written.
              alu_a_next  = '0;
              alu_b_next  = '0;
              alu_op_next = OP_NOP;
            end
            default: begin
              alu_a_next  = rs_data;
              alu_b_next  = rt_data;
              alu_op_next = in_op;
            end
          endcase
        end
      end

      EXEC: begin
        // ALU inputs have been stable all cycle; capture and write back.
        state_next    = WB;
        res_data_next = alu_result;
        res_rd_next   = rd_reg;
        wr_en         = !nop_reg;
      end

      WB: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_op_reg   <= 3'b000;
      rd_reg       <= 3'd0;
      nop_reg      <= 1'b0;
      res_data_reg <= '0;
      res_rd_reg   <= 3'd0;
    end else begin
      state_reg    <= state_next;
      alu_a_reg    <= alu_a_next;
      alu_b_reg    <= alu_b_next;
      alu_op_reg   <= alu_op_next;
      rd_reg       <= rd_next;
      nop_reg      <= nop_next;
      res_data_reg <= res_data_next;
      res_rd_reg   <= res_rd_next;
    end
  end

  // Register file update: reset clears all entries, so an aborted instruction never lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regfile_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) begin
          regfile_reg[i] <= alu_result;
        end
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign res_valid = (state_reg == WB);
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign res_data  = res_data_reg;
  assign res_rd    = res_rd_reg;
  assign dbg_data  = regfile_reg[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: provides the combinational ALU, drives directed and
// random instructions and compares against an architectural register model.
module tb_alu_issue_ctrl;

  localparam int W = 32;

  localparam logic [2:0] MOV = 3'b000;
  localparam logic [2:0] NOT = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] AND = 3'b101;
  localparam logic [2:0] LDI = 3'b110;
  localparam logic [2:0] NOP = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op, in_rd, in_rs, in_rt;
  logic [W-1:0] in_imm;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic [2:0]   res_rd;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  // Architectural register contents as the program should see them.
  logic [W-1:0] mregs [8];

  always #5 clk = ~clk;

  // The external ALU: R0 from R2/R3/ALUOp, default returns 0.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
    case (op)
      MOV:     return a;
      NOT:     return ~a;
      ADD:     return a + b;
      SUB:     return a - b;
      OR:      return a | b;
      AND:     return a & b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  // Instruction semantics in terms of register values.
  function automatic logic [W-1:0] ref_exec(input logic [2:0] op, input logic [W-1:0] vs,
                                            input logic [W-1:0] vt, input logic [W-1:0] imm);
    case (op)
      MOV:     return vs;
      NOT:     return ~vs;
      ADD:     return vs + vt;
      SUB:     return vs - vt;
      OR:      return vs | vt;
      AND:     return vs & vt;
      LDI:     return imm;
      default: return '0;
    endcase
  endfunction

  alu_issue_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [2:0] idx, input logic [W-1:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("dbg_r%0d", idx), dbg_data, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
  endtask

  // Issue one instruction from an IDLE negedge; returns at the negedge after WB.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [W-1:0] imm);
    logic [W-1:0] ea, eb, er;
    logic [2:0]   eop;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    case (op)
      LDI:     begin ea = imm; eb = '0; eop = MOV; end
      NOP:     begin ea = '0;  eb = '0; eop = NOP; end
      default: begin ea = mregs[rs]; eb = mregs[rt]; eop = op; end
    endcase
    er = ref_exec(op, mregs[rs], mregs[rt], imm);
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    @(posedge clk);
    #1;
    // Garbage on the inputs outside IDLE must be ignored.
    in_valid = 1'b0;
    in_op = 3'($urandom); in_rd = 3'($urandom); in_rs = 3'($urandom);
    in_rt = 3'($urandom); in_imm = $urandom;
    @(negedge clk);
    check("exec_ready", in_ready, 1'b0);
    check("exec_valid", res_valid, 1'b0);
    check("exec_alu_a", alu_a, ea);
    check("exec_alu_b", alu_b, eb);
    check("exec_alu_op", alu_op, eop);
    @(negedge clk);
    check("wb_valid", res_valid, 1'b1);
    check("wb_data", res_data, er);
    check("wb_rd", res_rd, rd);
    if (op != NOP) mregs[rd] = er;
    check_reg(rd, mregs[rd]);
    @(negedge clk);
    check("idle_valid", res_valid, 1'b0);
    check("idle_ready", in_ready, 1'b1);
    check("hold_data", res_data, er);
    check("hold_rd", res_rd, rd);
    $display("txn op=%0d rd=%0d rs=%0d rt=%0d imm=%h result=%h", op, rd, rs, rt, imm, res_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] simm;
    rst_n = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0; dbg_addr = '0;
    clear_model();

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    check("rst_res_rd", res_rd, '0);
    check("rst_alu_a", alu_a, '0);
    check("rst_alu_b", alu_b, '0);
    check("rst_alu_op", alu_op, '0);
    for (int i = 0; i < 8; i++) check_reg(3'(i), '0);

    // Basic loads and add
    issue(LDI, 3'd1, 3'd0, 3'd0, 32'd5);
    issue(LDI, 3'd2, 3'd0, 3'd0, 32'd3);
    issue(ADD, 3'd3, 3'd1, 3'd2, '0);
    check_reg(3'd3, 32'd8);

    // Wrapping subtract and NOT of zero
    issue(SUB, 3'd4, 3'd2, 3'd1, '0);
    check_reg(3'd4, 32'hFFFF_FFFE);
    issue(NOT, 3'd5, 3'd0, 3'd0, '0);
    check_reg(3'd5, 32'hFFFF_FFFF);

    // NOP leaves r3 alone; rs==rt==rd doubling
    issue(NOP, 3'd3, 3'd1, 3'd2, 32'hDEAD_BEEF);
    check_reg(3'd3, 32'd8);
    issue(ADD, 3'd1, 3'd1, 3'd1, '0);
    check_reg(3'd1, 32'd10);

    // Bit patterns through OR/AND
    issue(LDI, 3'd1, 3'd0, 3'd0, 32'hF0F0_F0F0);
    issue(LDI, 3'd2, 3'd0, 3'd0, 32'h0FF0_0FF0);
    issue(OR,  3'd6, 3'd1, 3'd2, '0);
    check_reg(3'd6, 32'hFFF0_FFF0);
    issue(AND, 3'd7, 3'd1, 3'd2, '0);
    check_reg(3'd7, 32'h00F0_00F0);

    // Continuous in_valid: ready 1,0,0 and res_valid 0,0,1
    simm = 32'h1234_5678;
    in_valid = 1'b1; in_op = LDI; in_rd = 3'd7; in_rs = 3'd0; in_rt = 3'd0; in_imm = simm;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("stream_ready_%0d", k), in_ready, W'(k % 3 == 0));
      check($sformatf("stream_valid_%0d", k), res_valid, W'(k % 3 == 2));
      if (k % 3 == 2) check($sformatf("stream_data_%0d", k), res_data, simm);
    end
    in_valid = 1'b0;
    mregs[7] = simm;
    $display("txn stream of 3x LDI r7 imm=%h", simm);
    @(negedge clk);
    check_reg(3'd7, simm);

    // Reset during EXEC aborts the instruction
    in_valid = 1'b1; in_op = LDI; in_rd = 3'd6; in_rs = 3'd0; in_rt = 3'd0; in_imm = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst_valid", res_valid, 1'b0);
    check("abort_rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid", res_valid, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_res_data", res_data, '0);
    clear_model();
    check_reg(3'd6, 32'd0);
    check_reg(3'd1, 32'd0);
    $display("txn reset during EXEC of LDI r6,9");

    // Random instruction stream against the model
    for (int t = 0; t < 40; t++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("gap_ready", in_ready, 1'b1);
      end
    end
    for (int i = 0; i < 8; i++) check_reg(3'(i), mregs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
